// File: rtl/bram_row_fetcher.sv
// Single-port BRAM arbiter: streams rows 0..NUM_ROWS-1 over valid/ready and slots game-logic writes between rows.
// Optional macro ROW_FETCH_CONTINUOUS_EN: rescan forever after the first frame instead of returning to IDLE.
module bram_row_fetcher #(
  parameter int DATA_WIDTH = 60,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_ROWS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_row,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_PRESENT = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ROW_ONE  = ADDR_WIDTH'(1);
`ifdef ROW_FETCH_CONTINUOUS_EN
  localparam logic CONTINUOUS = 1'b1;
`else
  localparam logic CONTINUOUS = 1'b0;
`endif

  state_t                r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_row, w_row;
  logic                  r_resume, w_resume;
  logic                  r_start_pending, w_start_pending;
  logic                  r_wr_ack, w_wr_ack;
  logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_din, w_ram_din;
  logic                  r_ram_we, w_ram_we;
  logic                  r_out_valid, w_out_valid;
  logic [ADDR_WIDTH-1:0] r_out_row, w_out_row;
  logic [DATA_WIDTH-1:0] r_out_data, w_out_data;
  logic                  r_frame_done, w_frame_done;
  logic                  w_scan_begin;
  logic                  w_last_row;
  logic [ADDR_WIDTH-1:0] w_row_inc;

  assign w_last_row = (r_row == LAST_ROW);
  assign w_row_inc  = w_last_row ? ROW_ZERO : (r_row + ROW_ONE);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state      = r_state;
    w_row        = r_row;
    w_resume     = r_resume;
    w_scan_begin = 1'b0;
    w_wr_ack     = 1'b0;
    w_ram_addr   = r_ram_addr;
    w_ram_din    = r_ram_din;
    w_ram_we     = 1'b0;
    w_out_valid  = r_out_valid;
    w_out_row    = r_out_row;
    w_out_data   = r_out_data;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wr_req) begin
          w_state    = S_WRITE;
          w_resume   = 1'b0;
          w_ram_we   = 1'b1;
          w_wr_ack   = 1'b1;
          w_ram_addr = wr_addr;
          w_ram_din  = wr_data;
        end else if (r_start_pending) begin
          w_state      = S_ISSUE;
          w_scan_begin = 1'b1;
          w_row        = ROW_ZERO;
          w_ram_addr   = ROW_ZERO;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_WRITE: begin
        w_resume = 1'b0;
        if (r_resume) begin
          w_state    = S_ISSUE;
          w_ram_addr = r_row;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_state = S_WAIT;
      end
      S_WAIT: begin
        w_state     = S_PRESENT;
        w_out_valid = 1'b1;
        w_out_row   = r_row;
        w_out_data  = ram_dout;
      end
      S_PRESENT: begin
        if (r_out_valid && out_ready) begin
          w_out_valid  = 1'b0;
          w_frame_done = w_last_row;
          if (!w_last_row || CONTINUOUS) begin
            w_row = w_row_inc;
            // A pending write takes the port before the next row is read.
            if (wr_req) begin
              w_state    = S_WRITE;
              w_resume   = 1'b1;
              w_ram_we   = 1'b1;
              w_wr_ack   = 1'b1;
              w_ram_addr = wr_addr;
              w_ram_din  = wr_data;
            end else begin
              w_state    = S_ISSUE;
              w_ram_addr = w_row_inc;
            end
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_state = S_PRESENT;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_start_pending = frame_start | (r_start_pending & ~w_scan_begin);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_row           <= ROW_ZERO;
      r_resume        <= 1'b0;
      r_start_pending <= 1'b0;
      r_wr_ack        <= 1'b0;
      r_ram_addr      <= ROW_ZERO;
      r_ram_din       <= {DATA_WIDTH{1'b0}};
      r_ram_we        <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_row       <= ROW_ZERO;
      r_out_data      <= {DATA_WIDTH{1'b0}};
      r_frame_done    <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_row           <= w_row;
      r_resume        <= w_resume;
      r_start_pending <= w_start_pending;
      r_wr_ack        <= w_wr_ack;
      r_ram_addr      <= w_ram_addr;
      r_ram_din       <= w_ram_din;
      r_ram_we        <= w_ram_we;
      r_out_valid     <= w_out_valid;
      r_out_row       <= w_out_row;
      r_out_data      <= w_out_data;
      r_frame_done    <= w_frame_done;
    end
  end

  assign wr_ack     = r_wr_ack;
  assign ram_addr   = r_ram_addr;
  assign ram_din    = r_ram_din;
  assign ram_we     = r_ram_we;
  assign out_valid  = r_out_valid;
  assign out_row    = r_out_row;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;

endmodule

// File: doc/bram_row_fetcher.md
Name: bram_row_fetcher

Overview:
- Controller between game logic and the single-port BRAM. It owns the RAM address, write-data and write-enable lines.
- On request it streams rows 0..NUM_ROWS-1 to the display/render stage over a valid/ready interface.
- Between rows it interleaves game-logic writes. Arbitration is needed because the RAM has one port.

Parameters:
- DATA_WIDTH, 60, width of one RAM word / row.
- ADDR_WIDTH, 4, RAM address width.
- NUM_ROWS, 16, rows per frame; must satisfy 1 <= NUM_ROWS <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  1-cycle pulse requesting a frame scan.
- wr_req  in  1  write request; held high until wr_ack.
- wr_addr  in  ADDR_WIDTH  write address; stable while wr_req is high.
- wr_data  in  DATA_WIDTH  write data; stable while wr_req is high.
- wr_ack  out  1  1-cycle pulse; the write is committed this cycle.
- ram_addr  out  ADDR_WIDTH  registered, drives the RAM address.
- ram_din  out  DATA_WIDTH  registered, drives the RAM write data.
- ram_we  out  1  registered, drives the RAM write enable.
- ram_dout  in  DATA_WIDTH  RAM read data; registered in the RAM, 1-cycle latency.
- out_valid  out  1  out_data/out_row valid.
- out_ready  in  1  downstream accepts the word.
- out_row  out  ADDR_WIDTH  row index of out_data.
- out_data  out  DATA_WIDTH  row word.
- frame_done  out  1  1-cycle pulse when the last row is accepted.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - State IDLE, row counter 0, start_pending 0.
  - Reset mid-frame aborts the scan; frame_done is not pulsed.
- start_pending: set by frame_start in any state, cleared when a scan begins. A frame_start during a scan queues one further frame; extra pulses merge.
- States:
  - IDLE:
    - wr_req=1 -> WRITE, with ram_we<=1, ram_addr<=wr_addr, ram_din<=wr_data.
    - Else if start_pending -> ISSUE, with row<=0, ram_addr<=0.
    - Writes win ties.
  - WRITE:
    - Lasts exactly one cycle; ram_we=1 and wr_ack=1 in that cycle.
    - Next: ram_we<=0; go to ISSUE if resume is set (ram_addr<=row), else IDLE.
    - The requester must drop wr_req in the cycle after wr_ack, otherwise a second write follows.
  - ISSUE: RAM samples ram_addr this cycle -> WAIT.
  - WAIT: out_data<=ram_dout, out_row<=row, out_valid<=1 -> PRESENT.
  - PRESENT:
    - Hold out_valid, out_data and out_row until out_valid&&out_ready.
    - On handshake: out_valid<=0.
    - If row==NUM_ROWS-1: frame_done<=1 for one cycle -> IDLE.
    - Else row<=row+1. If wr_req, go to WRITE with resume=1; otherwise go to ISSUE with ram_addr<=row+1.
- Latency:
  - frame_start sampled at edge E -> out_valid high after edge E+3, given IDLE, no wr_req and start_pending set at E.
  - Back-to-back rows with out_ready held high: one word every 3 cycles.
- A write that lands on a row not yet fetched is visible in the current frame.
- ram_we is never high while a read is in flight (ISSUE/WAIT).
- Row counter and out_row are ADDR_WIDTH wide; no wrap is possible because NUM_ROWS <= 2**ADDR_WIDTH.

Optional Feature:
- Macro: ROW_FETCH_CONTINUOUS_EN.
- Defined: after the last row's handshake, frame_done still pulses, but the state machine goes straight to ISSUE with row 0. If wr_req is high at that point, it goes to WRITE first with resume=1. Scanning repeats forever without frame_start, and start_pending is ignored.
- Undefined: the block returns to IDLE after each frame, as described above.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert rst while in PRESENT with out_valid=1.
  - Response: all outputs 0 immediately; after release, no frame_done and no out_valid until a new frame_start.
- Single write:
  - Stimulus: wr_req, wr_addr=3, wr_data=60'hABC from IDLE.
  - Response: next cycle ram_we=1, ram_addr=3, ram_din=60'hABC, wr_ack=1 for exactly one cycle. A subsequent frame returns 60'hABC on out_row=3.
- Full frame, no backpressure:
  - Stimulus: preload RAM row i with value i; pulse frame_start; hold out_ready=1.
  - Response: 16 words 0..15 with matching out_row, first out_valid 3 cycles after frame_start, spaced 3 cycles apart. frame_done pulses once with the row 15 handshake.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles on row 5.
  - Response: out_valid, out_row=5 and out_data held stable for all 10 cycles; row 6 follows after release.
- Write during a scan:
  - Stimulus: assert wr_req (addr 9, data 60'h55) while row 4 is presented, then hand-shake row 4.
  - Response: the write is granted before row 5 is issued; row 9 later reads 60'h55. ram_we is never high in ISSUE/WAIT.
- Start collisions:
  - Stimulus: frame_start asserted simultaneously with wr_req in IDLE; a second frame_start asserted during the scan.
  - Response: the write completes first, then frame 1 runs, then exactly one more frame.
